// File: rtl/proc_pkg.sv
// proc_pkg: shared datapath widths and ALU operation encoding
package proc_pkg;
  localparam int DW = 16;
  localparam int RF_AW = 4;
  localparam int DM_AW = 8;
  localparam int RF_DEPTH = 1 << RF_AW;
  localparam int DM_DEPTH = 1 << DM_AW;
  typedef enum logic [2:0] {
    ALU_ZERO, ALU_ADD, ALU_SUB, ALU_PASSA, ALU_XOR, ALU_OR, ALU_AND, ALU_INC
  } alu_op_e;
endpackage

// File: rtl/register_file.sv
// register_file: 16x16 register file, two combinational reads, one write, sync clear
module register_file
  import proc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [RF_AW-1:0] wa,
  input  logic [RF_AW-1:0] ra,
  input  logic [RF_AW-1:0] rb,
  input  logic [DW-1:0]    wd,
  output logic [DW-1:0]    ra_data,
  output logic [DW-1:0]    rb_data
);
  logic [DW-1:0] rf_q [RF_DEPTH];
  logic [DW-1:0] rf_d [RF_DEPTH];
  always_comb begin
    rf_d = rf_q;
    if (we) rf_d[wa] = wd;
  end
  always_ff @(posedge clk) begin
    if (reset) rf_q <= '{default: '0};
    else rf_q <= rf_d;
  end
  // reads see the pre-edge contents; no write bypass
  assign ra_data = rf_q[ra];
  assign rb_data = rf_q[rb];
endmodule

// File: rtl/datapath_unit.sv
// datapath_unit: register file, data memory, write-back mux and ALU driven by the control unit
module datapath_unit
  import proc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [DM_AW-1:0] D_addr,
  input  logic             D_Wr,
  input  logic             RF_s,
  input  logic             RF_W_en,
  input  logic [RF_AW-1:0] RF_W_addr,
  input  logic [RF_AW-1:0] RF_Ra_addr,
  input  logic [RF_AW-1:0] RF_Rb_addr,
  input  logic [2:0]       ALU_s0,
  output logic [DW-1:0]    Ra_data,
  output logic [DW-1:0]    Rb_data,
  output logic [DW-1:0]    ALU_Out,
  output logic             ALU_zero,
  output logic [DW-1:0]    W_data
);
  logic [DW-1:0] mem_q [DM_DEPTH];
  logic [DW-1:0] rd_q, rd_d, alu_out;
  register_file u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (RF_W_en),
    .wa      (RF_W_addr),
    .ra      (RF_Ra_addr),
    .rb      (RF_Rb_addr),
    .wd      (W_data),
    .ra_data (Ra_data),
    .rb_data (Rb_data)
  );
  always_comb begin
    alu_out = '0;
    case (alu_op_e'(ALU_s0))
      ALU_ZERO:  alu_out = '0;
      ALU_ADD:   alu_out = Ra_data + Rb_data;
      ALU_SUB:   alu_out = Ra_data - Rb_data;
      ALU_PASSA: alu_out = Ra_data;
      ALU_XOR:   alu_out = Ra_data ^ Rb_data;
      ALU_OR:    alu_out = Ra_data | Rb_data;
      ALU_AND:   alu_out = Ra_data & Rb_data;
      ALU_INC:   alu_out = Ra_data + DW'(1);
    endcase
  end
  assign rd_d = mem_q[D_addr];
  // memory contents survive reset; only the read register is cleared
  always_ff @(posedge clk) begin
    rd_q <= reset ? '0 : rd_d;
    if (D_Wr && !reset) mem_q[D_addr] <= Ra_data;
  end
  assign ALU_Out  = alu_out;
  assign ALU_zero = alu_out == '0;
  assign W_data   = RF_s ? rd_q : alu_out;
endmodule

// File: tb/tb_datapath_unit.sv
// tb_datapath_unit: scoreboard bench for datapath_unit against a behavioural model
module tb_datapath_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  D_addr = '0;
  logic        D_Wr = 1'b0, RF_s = 1'b0, RF_W_en = 1'b0;
  logic [3:0]  RF_W_addr = '0, RF_Ra_addr = '0, RF_Rb_addr = '0;
  logic [2:0]  ALU_s0 = '0;
  logic [15:0] Ra_data, Rb_data, ALU_Out, W_data;
  logic        ALU_zero;
  int total = 0, bad = 0;

  datapath_unit dut (
    .clk(clk), .reset(reset), .D_addr(D_addr), .D_Wr(D_Wr), .RF_s(RF_s),
    .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr), .ALU_s0(ALU_s0), .Ra_data(Ra_data),
    .Rb_data(Rb_data), .ALU_Out(ALU_Out), .ALU_zero(ALU_zero), .W_data(W_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ra, rb, alu, wd;
    logic        z;
    bit          wd_ok;
  } exp_t;
  exp_t sb[$];

  logic [15:0] m_rf [16];
  logic [15:0] m_mem [int];
  logic [15:0] m_rd;
  bit          m_rd_ok;

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, b);
    case (op)
      3'd0: return 16'h0000;
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a;
      3'd4: return a ^ b;
      3'd5: return a | b;
      3'd6: return a & b;
      default: return a + 16'h0001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [7:0] da, input logic dwr, rfs, we,
                       input logic [3:0] wa, raa, rba, input logic [2:0] op);
    exp_t e;
    reset = rst; D_addr = da; D_Wr = dwr; RF_s = rfs; RF_W_en = we;
    RF_W_addr = wa; RF_Ra_addr = raa; RF_Rb_addr = rba; ALU_s0 = op;
    e.ra = m_rf[raa];
    e.rb = m_rf[rba];
    e.alu = alu_f(op, e.ra, e.rb);
    e.z = (e.alu == 16'h0000);
    e.wd = rfs ? m_rd : e.alu;
    e.wd_ok = !rfs || m_rd_ok;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk("ra_data", Ra_data, e.ra);
    chk("rb_data", Rb_data, e.rb);
    chk("alu_out", ALU_Out, e.alu);
    chk("alu_zero", {15'd0, ALU_zero}, {15'd0, e.z});
    if (e.wd_ok) chk("w_data", W_data, e.wd);
  endtask

  task automatic tick();
    logic [15:0] a, wd;
    a = m_rf[RF_Ra_addr];
    wd = RF_s ? m_rd : alu_f(ALU_s0, a, m_rf[RF_Rb_addr]);
    @(posedge clk);
    if (reset) begin
      foreach (m_rf[i]) m_rf[i] = 16'h0000;
      m_rd = 16'h0000;
      m_rd_ok = 1'b1;
    end else begin
      m_rd_ok = m_mem.exists(int'(D_addr));
      if (m_rd_ok) m_rd = m_mem[int'(D_addr)];
      if (D_Wr) m_mem[int'(D_addr)] = a;
      if (RF_W_en) m_rf[RF_W_addr] = wd;
    end
    @(negedge clk);
  endtask

  task automatic step(input logic [7:0] da, input logic dwr, rfs, we,
                      input logic [3:0] wa, raa, rba, input logic [2:0] op);
    drive(1'b0, da, dwr, rfs, we, wa, raa, rba, op);
    tick();
  endtask

  // builds a constant in register r by doubling and incrementing
  task automatic set_reg(input logic [3:0] r, input logic [15:0] v);
    step(8'h00, 1'b0, 1'b0, 1'b1, r, r, r, 3'd0);
    for (int i = 15; i >= 0; i--) begin
      step(8'h00, 1'b0, 1'b0, 1'b1, r, r, r, 3'd1);
      if (v[i]) step(8'h00, 1'b0, 1'b0, 1'b1, r, r, r, 3'd7);
    end
  endtask

  logic [15:0] sweep [8];

  initial begin
    sweep = '{16'h0000, 16'h100E, 16'hF1F0, 16'h00FF, 16'h0FF0, 16'h0FFF, 16'h000F, 16'h0100};
    repeat (2) @(posedge clk);
    @(negedge clk);
    foreach (m_rf[i]) m_rf[i] = 16'h0000;
    m_rd = 16'h0000;
    m_rd_ok = 1'b1;

    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd15, 3'd1);
    chk("rst_ra", Ra_data, 16'h0000);
    chk("rst_rb", Rb_data, 16'h0000);
    chk("rst_zero", {15'd0, ALU_zero}, 16'h0001);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'd7);
    chk("rst_inc_zero", {15'd0, ALU_zero}, 16'h0000);
    tick();

    set_reg(4'd5, 16'h1234);
    step(8'h01, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 4'd0, 3'd0);
    step(8'h01, 1'b0, 1'b1, 1'b0, 4'd0, 4'd15, 4'd0, 3'd0);
    drive(1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 4'd15, 4'd15, 4'd0, 3'd0);
    chk("ldA_rf15_old", Ra_data, 16'h0000);
    chk("ldA_wdata", W_data, 16'h1234);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd15, 4'd0, 3'd3);
    chk("ldB_rf15", Ra_data, 16'h1234);
    tick();

    set_reg(4'd1, 16'h0005);
    set_reg(4'd2, 16'h0003);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3, 4'd1, 4'd2, 3'd1);
    chk("add", ALU_Out, 16'h0008);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0, 3'd3);
    chk("add_rf3", Ra_data, 16'h0008);
    tick();
    set_reg(4'd10, 16'h0001);
    set_reg(4'd9, 16'h0002);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 4'd10, 4'd9, 3'd2);
    chk("sub_wrap", ALU_Out, 16'hFFFF);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'd7);
    chk("sub_rf0", Ra_data, 16'hFFFF);
    chk("inc_wrap", ALU_Out, 16'h0000);
    chk("inc_wrap_zero", {15'd0, ALU_zero}, 16'h0001);
    tick();

    step(8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 3'd0);
    step(8'h02, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 3'd0);
    set_reg(4'd4, 16'hBEEF);
    step(8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 4'd0, 3'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd4, 4'd0, 3'd0);
    chk("rdw_old", W_data, 16'h0005);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd6, 4'd6, 4'd0, 3'd0);
    chk("st_ld_wdata", W_data, 16'hBEEF);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd6, 4'd0, 3'd3);
    chk("st_ld_rf6", Ra_data, 16'hBEEF);
    tick();

    set_reg(4'd7, 16'hAAAA);
    drive(1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 4'd7, 4'd7, 4'd0, 3'd3);
    tick();
    drive(1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 4'd0, 3'd3);
    chk("rst_rf7", Ra_data, 16'h0000);
    chk("rst_rdq", W_data, 16'h0000);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 4'd0, 3'd0);
      chk("halt_rf7", Ra_data, 16'h0000);
      chk("halt_mem2", W_data, 16'h0005);
      tick();
    end

    set_reg(4'd1, 16'h00FF);
    set_reg(4'd2, 16'h0F0F);
    for (int op = 0; op < 8; op++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2, 3'(op));
      chk("sweep", ALU_Out, sweep[op]);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
